// File: rtl/stb_hit_counter_pkg.sv
// Shared measure-unit definitions: hit-counter state encoding and default timing constants.
package stb_hit_counter_pkg;

    // One-hot, same style as the strobe generator's state register.
    typedef enum logic [6:0] {
        ST_IDLE       = 7'b000_0001,
        ST_REQ        = 7'b000_0010,
        ST_WAIT_DROP  = 7'b000_0100,
        ST_WAIT_VALID = 7'b000_1000,
        ST_SETTLE     = 7'b001_0000,
        ST_SAMPLE     = 7'b010_0000,
        ST_DONE       = 7'b100_0000
    } stb_hit_state_t;

    localparam int unsigned DEF_SETTLE_CYCLES  = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for asynchronous inputs, synchronous active-high reset.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/stb_hit_counter.sv
// Requests strobes one at a time, samples the synchronized comparator once each strobe has
// settled, and reports hit/total counts (or an abort) on a valid/ready result handshake.
module stb_hit_counter
    import stb_hit_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] n_samples_i,
    input  logic                 stb_rdy_i,
    output logic                 stb_req_o,
    input  logic                 stb_valid_i,
    input  logic                 cmp_i,
    output logic                 busy_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [CNT_WIDTH-1:0] hits_o,
    output logic [CNT_WIDTH-1:0] total_o,
    output logic                 err_o
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    stb_hit_state_t       state_q, state_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] hits_q, hits_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic                 err_q, err_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic                 busy_q;
    logic                 cmp_sync;

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cmp_i),
        .q_o   (cmp_sync)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        hits_d   = hits_q;
        total_d  = total_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = n_samples_i;
                    hits_d  = '0;
                    total_d = '0;
                    if (!stb_rdy_i) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (n_samples_i == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT_DROP;
            end
            // One timeout budget spans both wait states; it saturates at zero so a
            // late drop still leaves WAIT_VALID a single chance before aborting.
            ST_WAIT_DROP: begin
                if (!stb_valid_i) begin
                    state_d = ST_WAIT_VALID;
                    if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_WAIT_VALID: begin
                if (stb_valid_i) begin
                    settle_d = SET_LOAD;
                    state_d  = ST_SETTLE;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_SAMPLE;
                else                settle_d = settle_q - 1'b1;
            end
            ST_SAMPLE: begin
                total_d = total_q + 1'b1;
                hits_d  = hits_q + CNT_WIDTH'(cmp_sync);
                state_d = (total_d == n_q) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                if (res_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            hits_q   <= '0;
            total_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            hits_q   <= hits_d;
            total_q  <= total_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign stb_req_o   = (state_q == ST_REQ);
    assign res_valid_o = (state_q == ST_DONE);
    assign busy_o      = busy_q;
    assign hits_o      = hits_q;
    assign total_o     = total_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_stb_hit_counter.sv
// Bench for stb_hit_counter: a strobe-generator/comparator model drives the DUT while a
// table of directed measurements, hand-written corner sequences and random runs are checked.
module tb_stb_hit_counter;

    localparam int CW = 16;
    localparam int SC = 4;
    localparam int SS = 2;
    localparam int TC = 1024;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [CW-1:0] n_samples_i;
    logic          stb_rdy_i;
    logic          stb_req_o;
    logic          stb_valid_i;
    logic          cmp_i;
    logic          busy_o;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [CW-1:0] hits_o;
    logic [CW-1:0] total_o;
    logic          err_o;

    stb_hit_counter #(
        .CNT_WIDTH      (CW),
        .SETTLE_CYCLES  (SC),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .n_samples_i (n_samples_i),
        .stb_rdy_i   (stb_rdy_i),
        .stb_req_o   (stb_req_o),
        .stb_valid_i (stb_valid_i),
        .cmp_i       (cmp_i),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .hits_o      (hits_o),
        .total_o     (total_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Strobe generator + comparator model. Configuration is written by the main process only.
    int          drop_dly   = 2;
    int          rise_dly   = 20;
    int          stop_after = 1000;
    bit          rand_dly   = 1'b0;
    logic [31:0] cmp_pat    = '0;

    int req_cnt = 0, rise_cnt = 0, last_req_cyc = 0, last_rise_cyc = 0;
    int tim_seen = 0, tim_bad = 0, dbl_req = 0;

    initial begin
        int drop_at, rise_at, flip_at, cur_drop, cur_rise;
        logic prev_busy, prev_req;
        logic [CW-1:0] prev_total;
        drop_at = -1; rise_at = -1; flip_at = -1;
        prev_busy = 1'b0; prev_req = 1'b0; prev_total = '0;
        stb_valid_i = 1'b1;
        cmp_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (busy_o && !prev_busy) req_cnt = 0;
            // Each sample must land SETTLE+1 cycles after valid rose; the count is visible one cycle later.
            if (total_o == prev_total + 1'b1) begin
                tim_seen++;
                if (cyc - last_rise_cyc != SC + 2) tim_bad++;
            end
            if (stb_req_o) begin
                if (prev_req) dbl_req++;
                req_cnt++;
                last_req_cyc = cyc;
                cur_drop = rand_dly ? int'($urandom_range(1, 4))  : drop_dly;
                cur_rise = rand_dly ? int'($urandom_range(1, 30)) : rise_dly;
                drop_at = cyc + cur_drop;
                rise_at = (req_cnt <= stop_after) ? drop_at + cur_rise : -1;
            end
            if (cyc == drop_at) begin
                stb_valid_i = 1'b0;
                cmp_i = ~cmp_pat[(req_cnt - 1) % 32];
            end
            if (cyc == rise_at) begin
                stb_valid_i = 1'b1;
                cmp_i = cmp_pat[(req_cnt - 1) % 32];
                last_rise_cyc = cyc;
                rise_cnt++;
                flip_at = cyc + SC + 2;
            end
            if (cyc == flip_at) cmp_i = ~cmp_i;
            prev_busy = busy_o;
            prev_req = stb_req_o;
            prev_total = total_o;
        end
    end

    task automatic run_meas(input string name, input logic rdy, input int n, input logic [31:0] pat,
                            input int stop, input int drop, input int rise, input bit rnd,
                            input int rdy_wait, input bit poke, input int eh, input int et,
                            input bit ee, input int ereq, output int start_cyc, output int done_cyc);
        int k, tb0, ts0, db0;
        bit stable;
        cmp_pat = pat; stop_after = stop; drop_dly = drop; rise_dly = rise; rand_dly = rnd;
        @(negedge clk_i);
        stb_rdy_i = rdy;
        n_samples_i = CW'(n);
        start_i = 1'b1;
        start_cyc = cyc;
        tb0 = tim_bad; ts0 = tim_seen; db0 = dbl_req;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0;
        while (!res_valid_o && k < 20000) begin
            if (poke && k == 10) begin
                start_i = 1'b1;
                n_samples_i = CW'(n + 3);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            k++;
        end
        start_i = 1'b0;
        done_cyc = cyc;
        check_eq({name, " res_valid"}, res_valid_o, 1);
        check_eq({name, " hits"}, hits_o, eh);
        check_eq({name, " total"}, total_o, et);
        check_eq({name, " err"}, err_o, ee);
        check_eq({name, " busy"}, busy_o, 1);
        check_eq({name, " req pulses"}, req_cnt, ereq);
        check_eq({name, " samples timed"}, tim_seen - ts0, et);
        check_eq({name, " late samples"}, tim_bad - tb0, 0);
        check_eq({name, " wide req"}, dbl_req - db0, 0);
        stable = 1'b1;
        for (int i = 0; i < rdy_wait; i++) begin
            start_i = (poke && i == 0);
            @(negedge clk_i);
            if (!res_valid_o || hits_o != CW'(eh) || total_o != CW'(et) || err_o != ee) stable = 1'b0;
        end
        start_i = 1'b0;
        check_eq({name, " held stable"}, stable, 1);
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        check_eq({name, " valid dropped"}, res_valid_o, 0);
        check_eq({name, " idle"}, busy_o, 0);
        check_eq({name, " hits kept"}, hits_o, eh);
        check_eq({name, " total kept"}, total_o, et);
    endtask

    typedef struct {
        string       name;
        logic        rdy;
        int          n;
        logic [31:0] pat;
        int          stop;
        int          drop;
        int          rise;
        int          rdy_wait;
        bit          poke;
        int          eh;
        int          et;
        bit          ee;
        int          ereq;
        int          lat;      // -1: not checked
        bit          lat_req;  // latency measured from the last request instead of start
    } vec_t;

    initial begin
        vec_t vecs[6];
        int s_cyc, d_cyc, r0, k;

        rst_i = 1'b1; start_i = 1'b0; n_samples_i = '0; stb_rdy_i = 1'b1; res_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("reset stb_req", stb_req_o, 0);
        check_eq("reset busy", busy_o, 0);
        check_eq("reset res_valid", res_valid_o, 0);
        check_eq("reset hits", hits_o, 0);
        check_eq("reset total", total_o, 0);
        check_eq("reset err", err_o, 0);
        rst_i = 1'b0;

        vecs[0] = '{"basic",   1'b1, 8,  32'hFFFF_FFFF, 1000, 2, 20, 50, 1'b0, 8, 8,  1'b0, 8,  -1,     1'b0};
        vecs[1] = '{"mixed",   1'b1, 10, 32'h0000_0155, 1000, 2, 20, 3,  1'b0, 5, 10, 1'b0, 10, -1,     1'b0};
        vecs[2] = '{"notrdy",  1'b0, 5,  32'h0000_00FF, 1000, 2, 20, 2,  1'b0, 0, 0,  1'b1, 0,  1,      1'b0};
        vecs[3] = '{"nzero",   1'b1, 0,  32'h0000_00FF, 1000, 2, 20, 2,  1'b0, 0, 0,  1'b0, 0,  1,      1'b0};
        vecs[4] = '{"timeout", 1'b1, 4,  32'h0000_000F, 2,    2, 20, 2,  1'b0, 2, 2,  1'b1, 3,  TC + 1, 1'b1};
        vecs[5] = '{"poke",    1'b1, 3,  32'h0000_0005, 1000, 3, 5,  5,  1'b1, 2, 3,  1'b0, 3,  -1,     1'b0};

        foreach (vecs[i]) begin
            run_meas(vecs[i].name, vecs[i].rdy, vecs[i].n, vecs[i].pat, vecs[i].stop, vecs[i].drop,
                     vecs[i].rise, 1'b0, vecs[i].rdy_wait, vecs[i].poke, vecs[i].eh, vecs[i].et,
                     vecs[i].ee, vecs[i].ereq, s_cyc, d_cyc);
            if (vecs[i].lat >= 0)
                check_eq({vecs[i].name, " latency"},
                         d_cyc - (vecs[i].lat_req ? last_req_cyc : s_cyc), vecs[i].lat);
        end

        // Reset during SETTLE of the third strobe, then a fresh short run.
        cmp_pat = 32'hFF; stop_after = 1000; drop_dly = 2; rise_dly = 10; rand_dly = 1'b0;
        r0 = rise_cnt;
        @(negedge clk_i);
        stb_rdy_i = 1'b1; n_samples_i = CW'(5); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0;
        while (rise_cnt < r0 + 3 && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        check_eq("midrun third strobe reached", rise_cnt - r0, 3);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_eq("midrun rst stb_req", stb_req_o, 0);
        check_eq("midrun rst busy", busy_o, 0);
        check_eq("midrun rst res_valid", res_valid_o, 0);
        check_eq("midrun rst hits", hits_o, 0);
        check_eq("midrun rst total", total_o, 0);
        check_eq("midrun rst err", err_o, 0);
        run_meas("after rst", 1'b1, 2, 32'h2, 1000, 2, 8, 1'b0, 2, 1'b0, 1, 2, 1'b0, 2, s_cyc, d_cyc);

        // Random runs against a result model: strobes that answer are sampled, the first silent one aborts.
        for (int it = 0; it < 6; it++) begin
            int n, stop, resp, eh, ereq;
            logic [31:0] pat;
            bit ee;
            n = int'($urandom_range(1, 8));
            pat = $urandom;
            stop = (it == 3) ? int'($urandom_range(0, n - 1)) : 1000;
            resp = (stop < n) ? stop : n;
            eh = 0;
            for (int j = 0; j < resp; j++) eh += int'(pat[j]);
            ee = (stop < n);
            ereq = ee ? stop + 1 : n;
            run_meas($sformatf("rand%0d", it), 1'b1, n, pat, stop, 2, 20, 1'b1,
                     int'($urandom_range(0, 6)), 1'b0, eh, resp, ee, ereq, s_cyc, d_cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
